// File: rtl/vcr_cmd_scheduler.sv
// VCR command scheduler: arbitrates front-panel and remote requests, issues one
// registered button pulse per command and waits for the tape controller to reach
// the requested status, reporting done or err.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no command in flight; arbitrate panel over remote FIFO
// ISSUE | one cycle; button drive for the latched command is registered
// WAIT  | watch tape_st for the target bit; stop preempts; timeout -> err
module vcr_cmd_scheduler #(
    parameter int unsigned TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] pnl_btn,
    input  logic [2:0] rc_cmd,
    input  logic       rc_valid,
    output logic       rc_ready,
    input  logic [5:0] tape_st,
    output logic       stop_button,
    output logic       pause_button,
    output logic       play_button,
    output logic       record_button,
    output logic       forward_button,
    output logic       rewind_button,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // Command codes double as bit indices into pnl_btn and tape_st.
    localparam logic [2:0] CMD_STOP    = 3'd0;
    localparam logic [2:0] CMD_PAUSE   = 3'd1;
    localparam logic [2:0] CMD_PLAY    = 3'd2;
    localparam logic [2:0] CMD_RECORD  = 3'd3;
    localparam logic [2:0] CMD_FORWARD = 3'd4;
    localparam logic [2:0] CMD_REWIND  = 3'd5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] cmd_q,   cmd_d;
    logic [2:0] tgt_q,   tgt_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [5:0] btn_q,   btn_d;
    logic       done_q,  done_d;
    logic       err_q,   err_d;

    logic [2:0] fifo_q [4];
    logic [1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0] count_q;
    logic       fifo_full, fifo_empty;
    logic       push_hs, push_store, pop;
    logic [2:0] fifo_head;

    logic       sel_valid;
    logic [2:0] sel_cmd;
    logic [2:0] pnl_cmd;

    assign fifo_full  = (count_q == 3'd4);
    assign fifo_empty = (count_q == 3'd0);
    assign fifo_head  = fifo_q[rd_ptr_q];
    // A pop in the same cycle frees a slot, so a full FIFO still accepts a push.
    assign rc_ready   = !fifo_full || pop;
    assign push_hs    = rc_valid && rc_ready;
    // Codes 6 and 7 complete the handshake but are never stored.
    assign push_store = push_hs && (rc_cmd <= CMD_REWIND);

    // Panel priority: stop > record > play > forward > rewind > pause.
    always_comb begin
        pnl_cmd = CMD_PAUSE;
        if (pnl_btn[0])      pnl_cmd = CMD_STOP;
        else if (pnl_btn[3]) pnl_cmd = CMD_RECORD;
        else if (pnl_btn[2]) pnl_cmd = CMD_PLAY;
        else if (pnl_btn[4]) pnl_cmd = CMD_FORWARD;
        else if (pnl_btn[5]) pnl_cmd = CMD_REWIND;
    end

    // Remote FIFO storage and pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) fifo_q[i] <= 3'd0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push_store) begin
                fifo_q[wr_ptr_q] <= rc_cmd;
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            case ({push_store, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Next-state logic: arbitration, issue decode, completion/preempt/timeout.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;
        btn_d     = 6'b000000;
        done_d    = 1'b0;
        err_d     = 1'b0;
        pop       = 1'b0;
        sel_valid = 1'b0;
        sel_cmd   = CMD_STOP;
        case (state_q)
            ST_IDLE: begin
                if (pnl_btn != 6'b000000) begin
                    sel_valid = 1'b1;
                    sel_cmd   = pnl_cmd;
                end else if (!fifo_empty) begin
                    sel_valid = 1'b1;
                    sel_cmd   = fifo_head;
                    pop       = 1'b1;
                end
                if (sel_valid) begin
                    if (sel_cmd == CMD_PAUSE) begin
                        // Pause toggles: playing -> wait for pause, paused -> wait for play.
                        if (tape_st[CMD_PLAY]) begin
                            cmd_d   = sel_cmd;
                            tgt_d   = CMD_PAUSE;
                            state_d = ST_ISSUE;
                        end else if (tape_st[CMD_PAUSE]) begin
                            cmd_d   = sel_cmd;
                            tgt_d   = CMD_PLAY;
                            state_d = ST_ISSUE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        cmd_d   = sel_cmd;
                        tgt_d   = sel_cmd;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                case (cmd_q)
                    CMD_STOP:    btn_d = 6'b000001;
                    CMD_PAUSE:   btn_d = 6'b000010;
                    CMD_PLAY:    btn_d = 6'b000100;
                    CMD_RECORD:  btn_d = 6'b001100;
                    CMD_FORWARD: btn_d = 6'b010000;
                    CMD_REWIND:  btn_d = 6'b100000;
                    default:     btn_d = 6'b000000;
                endcase
                cnt_d   = 8'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tape_st[tgt_q]) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (pnl_btn[0]) begin
                    err_d   = 1'b1;
                    cmd_d   = CMD_STOP;
                    tgt_d   = CMD_STOP;
                    state_d = ST_ISSUE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_STOP;
            tgt_q   <= CMD_STOP;
            cnt_q   <= 8'd0;
            btn_q   <= 6'b000000;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            btn_q   <= btn_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign stop_button    = btn_q[0];
    assign pause_button   = btn_q[1];
    assign play_button    = btn_q[2];
    assign record_button  = btn_q[3];
    assign forward_button = btn_q[4];
    assign rewind_button  = btn_q[5];
    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;
    assign err            = err_q;

endmodule
